// File: rtl/ahbmtx_l1_pkg.sv
// -----------------------------------------------------------------------------
// ahbmtx_l1_pkg
// Shared definitions for the L1 AHB bus matrix: HTRANS/HRESP encodings,
// default address/user widths and the packed address-phase control payload.
// -----------------------------------------------------------------------------
package ahbmtx_l1_pkg;

  // Default bus widths; blocks expose them as overridable parameters.
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned USER_W = 32;

  // HTRANS encodings.
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // HRESP encodings.
  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  // Fixed-width address-phase controls travelling with every transfer.
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       mastlock;
  } ahb_ctrl_t;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY do not.
  function automatic logic trans_is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahbmtx_l1_hold_reg.sv
// -----------------------------------------------------------------------------
// ahbmtx_l1_hold_reg
// Enable-loaded bank holding one captured AHB address phase. Loads every
// cycle the enable is high; clears to an idle, deselected transfer on reset.
//
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   load                  capture enable
//   sel, addr, trans,
//   ctrl, auser           live address-phase fields to capture
//   held_*                captured copy of the same fields
// -----------------------------------------------------------------------------
module ahbmtx_l1_hold_reg
  import ahbmtx_l1_pkg::*;
#(
  parameter int unsigned ADDR_W = ahbmtx_l1_pkg::ADDR_W,
  parameter int unsigned USER_W = ahbmtx_l1_pkg::USER_W
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              load,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        trans,
  input  ahb_ctrl_t         ctrl,
  input  logic [USER_W-1:0] auser,
  output logic              held_sel,
  output logic [ADDR_W-1:0] held_addr,
  output logic [1:0]        held_trans,
  output ahb_ctrl_t         held_ctrl,
  output logic [USER_W-1:0] held_auser
);

  // Address-phase capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held_sel   <= 1'b0;
      held_addr  <= '0;
      held_trans <= HTRANS_IDLE;
      held_ctrl  <= '0;
      held_auser <= '0;
    end else if (load) begin
      held_sel   <= sel;
      held_addr  <= addr;
      held_trans <= trans;
      held_ctrl  <= ctrl;
      held_auser <= auser;
    end
  end

endmodule

// File: rtl/ahbmtx_l1_in_stage.sv
// -----------------------------------------------------------------------------
// ahbmtx_l1_in_stage
// Per-port input stage of the L1 AHB matrix. Transfers pass straight to the
// decoder while the target output stage grants this port. When a transfer is
// requested but not granted, it is captured, the master is stalled, and the
// captured address phase is replayed to the decoder until the grant arrives.
//
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   HSELS..HAUSERS, HREADYS       address phase and HREADY from the master
//   HREADYOUTS, HRESPS            data-phase response to the master
//   sel_in..auser_in, ready_in    address phase and HREADY to the decoder
//   active_dec                    output stage currently granted to this port
//   readyout_dec, resp_dec        data-phase response from the decoder
// -----------------------------------------------------------------------------
module ahbmtx_l1_in_stage
  import ahbmtx_l1_pkg::*;
#(
  parameter int unsigned ADDR_W = ahbmtx_l1_pkg::ADDR_W,
  parameter int unsigned USER_W = ahbmtx_l1_pkg::USER_W
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  // master side
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic [USER_W-1:0] HAUSERS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  // decoder side
  output logic              sel_in,
  output logic [ADDR_W-1:0] addr_in,
  output logic [1:0]        trans_in,
  output logic              write_in,
  output logic [2:0]        size_in,
  output logic [2:0]        burst_in,
  output logic [3:0]        prot_in,
  output logic              mastlock_in,
  output logic [USER_W-1:0] auser_in,
  output logic              ready_in,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic [1:0]        resp_dec
);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t            state;
  logic              pend;
  logic              trans_req;
  logic              hold_load;
  ahb_ctrl_t         live_ctrl;
  ahb_ctrl_t         mux_ctrl;
  logic              held_sel;
  logic [ADDR_W-1:0] held_addr;
  logic [1:0]        held_trans;
  ahb_ctrl_t         held_ctrl;
  logic [USER_W-1:0] held_auser;

  assign pend      = (state == ST_PEND);
  assign trans_req = HSELS & trans_is_active(HTRANSS) & HREADYS;
  // The hold bank tracks every completed address phase until a stall freezes it.
  assign hold_load = HREADYS & ~pend;
  assign live_ctrl = {HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};

  ahbmtx_l1_hold_reg #(
    .ADDR_W (ADDR_W),
    .USER_W (USER_W)
  ) u_hold (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .load       (hold_load),
    .sel        (HSELS),
    .addr       (HADDRS),
    .trans      (HTRANSS),
    .ctrl       (live_ctrl),
    .auser      (HAUSERS),
    .held_sel   (held_sel),
    .held_addr  (held_addr),
    .held_trans (held_trans),
    .held_ctrl  (held_ctrl),
    .held_auser (held_auser)
  );

  // Stall tracking: enter on an ungranted request, leave on the granted replay.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_PASS;
    end else begin
      case (state)
        ST_PASS: if (trans_req && !active_dec) state <= ST_PEND;
        ST_PEND: if (active_dec) state <= ST_PASS;
        default: state <= ST_PASS;
      endcase
    end
  end

  // Decoder-side and master-side muxing between live and held transfer.
  always_comb begin
    sel_in     = HSELS;
    addr_in    = HADDRS;
    trans_in   = HTRANSS;
    mux_ctrl   = live_ctrl;
    auser_in   = HAUSERS;
    ready_in   = HREADYS;
    HREADYOUTS = readyout_dec;
    HRESPS     = resp_dec;
    if (pend) begin
      sel_in     = 1'b1;
      addr_in    = held_addr;
      trans_in   = held_trans;
      mux_ctrl   = held_ctrl;
      auser_in   = held_auser;
      // The previous data phase had completed when the hold was taken.
      ready_in   = active_dec;
      HREADYOUTS = 1'b0;
      HRESPS     = HRESP_OKAY;
    end
  end

  assign write_in    = mux_ctrl.write;
  assign size_in     = mux_ctrl.size;
  assign burst_in    = mux_ctrl.burst;
  assign prot_in     = mux_ctrl.prot;
  assign mastlock_in = mux_ctrl.mastlock;

  // held_sel is implied by pend (only selected requests stall); kept for debug visibility.
  logic unused_held_sel;
  assign unused_held_sel = held_sel;

endmodule

// File: tb/tb_ahbmtx_l1_in_stage.sv
// -----------------------------------------------------------------------------
// tb_ahbmtx_l1_in_stage
// Self-checking bench: directed scenarios with literal expectations followed
// by randomized traffic, all compared every cycle against a transfer-level
// reference model (a stall flag plus the one blocked transfer), and a beat
// log confirming every accepted transfer reaches the decoder once, in order.
// -----------------------------------------------------------------------------
module tb_ahbmtx_l1_in_stage;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic [31:0] HAUSERS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_in;
  logic [31:0] addr_in;
  logic [1:0]  trans_in;
  logic        write_in;
  logic [2:0]  size_in;
  logic [2:0]  burst_in;
  logic [3:0]  prot_in;
  logic        mastlock_in;
  logic [31:0] auser_in;
  logic        ready_in;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;

  // Single master on this port: its HREADY is the port's own HREADYOUT.
  assign HREADYS = HREADYOUTS;

  ahbmtx_l1_in_stage #(.ADDR_W(32), .USER_W(32)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSELS       (HSELS),
    .HADDRS      (HADDRS),
    .HTRANSS     (HTRANSS),
    .HWRITES     (HWRITES),
    .HSIZES      (HSIZES),
    .HBURSTS     (HBURSTS),
    .HPROTS      (HPROTS),
    .HMASTLOCKS  (HMASTLOCKS),
    .HAUSERS     (HAUSERS),
    .HREADYS     (HREADYS),
    .HREADYOUTS  (HREADYOUTS),
    .HRESPS      (HRESPS),
    .sel_in      (sel_in),
    .addr_in     (addr_in),
    .trans_in    (trans_in),
    .write_in    (write_in),
    .size_in     (size_in),
    .burst_in    (burst_in),
    .prot_in     (prot_in),
    .mastlock_in (mastlock_in),
    .auser_in    (auser_in),
    .ready_in    (ready_in),
    .active_dec  (active_dec),
    .readyout_dec(readyout_dec),
    .resp_dec    (resp_dec)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        mastlock;
    logic [31:0] auser;
  } xfer_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  // reference model state
  logic        m_stalled;
  xfer_t       m_held;
  logic        e_hro;
  logic [31:0] issued[$];
  logic [31:0] presented[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic xfer_t live_xfer();
    xfer_t x;
    x.sel = HSELS; x.addr = HADDRS; x.trans = HTRANSS; x.write = HWRITES;
    x.size = HSIZES; x.burst = HBURSTS; x.prot = HPROTS; x.mastlock = HMASTLOCKS;
    x.auser = HAUSERS;
    return x;
  endfunction

  // Reset drops any blocked transfer: it never reaches the decoder.
  task automatic model_reset();
    if (m_stalled) void'(issued.pop_back());
    m_stalled = 1'b0;
  endtask

  // Compare all DUT outputs to the model at mid-cycle, then advance the model.
  task automatic sample();
    xfer_t       e;
    logic        e_ready;
    logic [1:0]  e_resp;
    @(negedge HCLK);
    if (m_stalled) begin
      e = m_held; e.sel = 1'b1;
      e_hro = 1'b0; e_resp = 2'b00; e_ready = active_dec;
    end else begin
      e = live_xfer();
      e_hro = readyout_dec; e_resp = resp_dec; e_ready = e_hro;
    end
    chk("sel_in",      64'(sel_in),      64'(e.sel));
    chk("addr_in",     64'(addr_in),     64'(e.addr));
    chk("trans_in",    64'(trans_in),    64'(e.trans));
    chk("write_in",    64'(write_in),    64'(e.write));
    chk("size_in",     64'(size_in),     64'(e.size));
    chk("burst_in",    64'(burst_in),    64'(e.burst));
    chk("prot_in",     64'(prot_in),     64'(e.prot));
    chk("mastlock_in", 64'(mastlock_in), 64'(e.mastlock));
    chk("auser_in",    64'(auser_in),    64'(e.auser));
    chk("ready_in",    64'(ready_in),    64'(e_ready));
    chk("HREADYOUTS",  64'(HREADYOUTS),  64'(e_hro));
    chk("HRESPS",      64'(HRESPS),      64'(e_resp));
    if (HRESETn) begin
      if (ready_in && sel_in && trans_in[1] && active_dec) presented.push_back(addr_in);
      if (!m_stalled) begin
        if (HSELS && HTRANSS[1] && e_hro) begin
          issued.push_back(HADDRS);
          if (!active_dec) begin
            m_stalled = 1'b1;
            m_held    = live_xfer();
          end
        end
      end else if (active_dec) begin
        m_stalled = 1'b0;
      end
    end
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_xfer(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                          input logic write, input logic [2:0] burst);
    HSELS = sel; HADDRS = addr; HTRANSS = trans; HWRITES = write;
    HSIZES = 3'd2; HBURSTS = burst; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
    HAUSERS = addr ^ 32'hA5A5_0000;
  endtask

  initial begin
    int ws;
    int base;
    HRESETn = 1'b0; active_dec = 1'b0; readyout_dec = 1'b1; resp_dec = 2'b00;
    set_xfer(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    m_stalled = 1'b0; m_held = '0; e_hro = 1'b0;
    repeat (2) sample();
    @(posedge HCLK); #2; HRESETn = 1'b1;
    sample();
    chk("rst_trans_in", 64'(trans_in), 64'(2'b00));
    chk("rst_hreadyout", 64'(HREADYOUTS), 64'(1'b1));

    // 1: granted NONSEQ write passes in the same cycle
    nxt(); set_xfer(1'b1, 32'h6009_0000, 2'b10, 1'b1, 3'd0); active_dec = 1'b1;
    sample();
    chk("t1_sel", 64'(sel_in), 64'(1'b1));
    chk("t1_addr", 64'(addr_in), 64'(32'h6009_0000));
    chk("t1_trans", 64'(trans_in), 64'(2'b10));
    nxt(); set_xfer(1'b0, 32'h0, 2'b00, 1'b0, 3'd0); readyout_dec = 1'b0;
    sample(); chk("t1_dp_wait", 64'(HREADYOUTS), 64'(1'b0));
    nxt(); readyout_dec = 1'b1;
    sample(); chk("t1_dp_done", 64'(HREADYOUTS), 64'(1'b1));

    // 2: blocked NONSEQ held for 3 ungranted cycles plus the grant cycle
    nxt(); set_xfer(1'b1, 32'h4003_0004, 2'b10, 1'b0, 3'd0); active_dec = 1'b0;
    sample(); chk("t2_req_hro", 64'(HREADYOUTS), 64'(1'b1));
    for (int i = 0; i < 4; i++) begin
      nxt(); HADDRS = 32'hDEAD_0000; resp_dec = 2'b01; active_dec = (i == 3);
      sample();
      chk("t2_hro", 64'(HREADYOUTS), 64'(1'b0));
      chk("t2_resp", 64'(HRESPS), 64'(2'b00));
      chk("t2_addr_held", 64'(addr_in), 64'(32'h4003_0004));
      chk("t2_ready_in", 64'(ready_in), 64'(i == 3));
      if (i == 0) chk("t2_model_hro", 64'(e_hro), 64'(1'b0));
    end
    nxt(); set_xfer(1'b0, 32'hDEAD_0000, 2'b00, 1'b0, 3'd0); resp_dec = 2'b00; active_dec = 1'b0;
    sample();
    chk("t2_back_hro", 64'(HREADYOUTS), 64'(1'b1));
    chk("t2_back_addr", 64'(addr_in), 64'(32'hDEAD_0000));

    // 3: IDLE never stalls even without a grant
    nxt(); set_xfer(1'b1, 32'h3000_0000, 2'b00, 1'b0, 3'd0);
    sample(); chk("t3_idle_hro", 64'(HREADYOUTS), 64'(1'b1));
    nxt(); sample(); chk("t3_idle_stay", 64'(HREADYOUTS), 64'(1'b1));

    // 4: two-cycle ERROR passes through; transfer in 2nd cycle is held
    nxt(); set_xfer(1'b0, 32'h0, 2'b00, 1'b0, 3'd0); resp_dec = 2'b01; readyout_dec = 1'b0;
    sample();
    chk("t4_err1_resp", 64'(HRESPS), 64'(2'b01));
    chk("t4_err1_hro", 64'(HREADYOUTS), 64'(1'b0));
    nxt(); set_xfer(1'b1, 32'h2000_0010, 2'b10, 1'b1, 3'd0); readyout_dec = 1'b1;
    sample();
    chk("t4_err2_resp", 64'(HRESPS), 64'(2'b01));
    chk("t4_err2_hro", 64'(HREADYOUTS), 64'(1'b1));
    nxt(); resp_dec = 2'b00;
    sample();
    chk("t4_pend_hro", 64'(HREADYOUTS), 64'(1'b0));
    chk("t4_pend_addr", 64'(addr_in), 64'(32'h2000_0010));
    chk("t4_model_stalled", 64'(m_stalled), 64'(1'b1));

    // 5: reset during the stall clears it immediately and drops the transfer
    nxt(); #1;
    HRESETn = 1'b0; set_xfer(1'b0, 32'h0, 2'b00, 1'b0, 3'd0); readyout_dec = 1'b1;
    model_reset();
    #1;
    chk("t5_async_hro", 64'(HREADYOUTS), 64'(1'b1));
    chk("t5_async_trans", 64'(trans_in), 64'(2'b00));
    readyout_dec = 1'b0; #1;
    chk("t5_async_follow", 64'(HREADYOUTS), 64'(1'b0));
    readyout_dec = 1'b1;
    sample();
    nxt(); #1; HRESETn = 1'b1; active_dec = 1'b1;
    sample();
    chk("t5_no_replay_trans", 64'(trans_in), 64'(2'b00));
    chk("t5_no_replay_sel", 64'(sel_in), 64'(1'b0));
    nxt(); sample();

    // 6: burst with grant 1,0,1 -> beat 2 takes two wait states
    base = presented.size();
    nxt(); set_xfer(1'b1, 32'h1000_0000, 2'b10, 1'b0, 3'b011); active_dec = 1'b1;
    sample(); chk("t6_b1_addr", 64'(addr_in), 64'(32'h1000_0000));
    nxt(); set_xfer(1'b1, 32'h1000_0004, 2'b11, 1'b0, 3'b011); active_dec = 1'b0;
    sample(); chk("t6_b1_dp", 64'(HREADYOUTS), 64'(1'b1));
    ws = 0;
    nxt(); sample(); if (!HREADYOUTS) ws++;
    chk("t6_blocked_ready", 64'(ready_in), 64'(1'b0));
    nxt(); active_dec = 1'b1;
    sample(); if (!HREADYOUTS) ws++;
    chk("t6_replay_addr", 64'(addr_in), 64'(32'h1000_0004));
    chk("t6_replay_ready", 64'(ready_in), 64'(1'b1));
    nxt(); set_xfer(1'b1, 32'h1000_0008, 2'b11, 1'b0, 3'b011);
    sample(); chk("t6_b3_hro", 64'(HREADYOUTS), 64'(1'b1));
    chk("t6_wait_states", 64'(ws), 64'(2));
    nxt(); set_xfer(1'b1, 32'h1000_000C, 2'b11, 1'b0, 3'b011); sample();
    nxt(); set_xfer(1'b0, 32'h0, 2'b00, 1'b0, 3'd0); sample();
    chk("t6_beat_count", 64'(presented.size() - base), 64'(4));
    for (int i = 0; i < 4; i++)
      if (base + i < presented.size())
        chk("t6_beat_order", 64'(presented[base + i]), 64'(32'h1000_0000 + 32'(4 * i)));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      nxt();
      HSELS        = ($urandom_range(0, 4) != 0);
      HADDRS       = $urandom;
      HTRANSS      = 2'($urandom_range(0, 3));
      HWRITES      = 1'($urandom_range(0, 1));
      HSIZES       = 3'($urandom_range(0, 7));
      HBURSTS      = 3'($urandom_range(0, 7));
      HPROTS       = 4'($urandom_range(0, 15));
      HMASTLOCKS   = 1'($urandom_range(0, 1));
      HAUSERS      = $urandom;
      active_dec   = ($urandom_range(0, 2) != 0);
      readyout_dec = ($urandom_range(0, 4) != 0);
      resp_dec     = 2'($urandom_range(0, 3));
      sample();
    end

    // Drain any blocked transfer, then reconcile the beat logs
    nxt(); set_xfer(1'b0, 32'h0, 2'b00, 1'b0, 3'd0); active_dec = 1'b1; readyout_dec = 1'b1;
    resp_dec = 2'b00;
    repeat (3) begin sample(); nxt(); end
    sample();
    chk("beats_total", 64'(presented.size()), 64'(issued.size()));
    for (int i = 0; i < issued.size(); i++)
      if (i < presented.size())
        chk("beat_order", 64'(presented[i]), 64'(issued[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbmtx_l1_in_stage.md
Name: ahbmtx_l1_in_stage

Overview:
Per-slave-port input stage of the L1 AHB bus matrix. It sits between one external master port and that port's address decoder. It captures each accepted address phase in a holding register. When the decoder reports the target output stage busy (active_dec low), it stalls the master and replays the held transfer once granted. The decoder's data-phase response returns to the master through this block.

Parameters:
ADDR_W, 32, address width; decoder consumes addr_in[ADDR_W-1:10]
USER_W, 32, HAUSER sideband width

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HSELS  in  1  port select from master
HADDRS  in  ADDR_W  address
HTRANSS  in  2  transfer type
HWRITES  in  1  write
HSIZES  in  3  size
HBURSTS  in  3  burst
HPROTS  in  4  protection
HMASTLOCKS  in  1  locked
HAUSERS  in  USER_W  address user
HREADYS  in  1  bus HREADY seen by master
HREADYOUTS  out  1  ready to master
HRESPS  out  2  response to master
sel_in  out  1  select to decoder
addr_in  out  ADDR_W  address to decoder
trans_in  out  2  HTRANS to decoder
write_in, size_in, burst_in, prot_in, mastlock_in, auser_in  out  1/3/3/4/1/USER_W  control to decoder
ready_in  out  1  HREADY to decoder/output stages
active_dec  in  1  target output stage granted this port
readyout_dec  in  1  decoder HREADYOUT
resp_dec  in  2  decoder HRESP

Behaviour:
- Reset HRESETn is asynchronous, active-low; clock HCLK. All registers are reset: pend=0, holding registers all 0 (trans IDLE).
- trans_req = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ accepted).
- Holding register load: when HREADYS=1 and pend=0, capture all address-phase inputs (HSELS, HADDRS, HTRANSS, controls). No load while pend=1.
- Two states:
  - PASS (pend=0):
    - Decoder outputs are the live master inputs; ready_in = HREADYS.
    - If trans_req & ~active_dec -> PEND next cycle.
    - If trans_req & active_dec -> stay PASS; the output stage samples the transfer directly.
  - PEND (pend=1):
    - Decoder outputs come from the holding register, with sel_in=1.
    - ready_in = active_dec: the previous data phase completed when the hold was taken, so the replayed address phase may be sampled as soon as the port is granted.
    - If active_dec=1 -> PASS next cycle.
    - Else remain PEND; no timeout.
- HREADYOUTS:
  - pend=1 -> 0.
  - pend=0 -> readyout_dec.
- HRESPS:
  - pend=1 -> OKAY (2'b00).
  - pend=0 -> resp_dec.
- Latency:
  - Granted at request: 0 added cycles.
  - Blocked: the master sees N+1 extra wait states, where N is the number of cycles active_dec stays low. The final wait state is the granted replay cycle.
- HTRANS IDLE/BUSY never enter PEND; they pass through with HREADYOUTS from the decoder (default slave = ready, OKAY).
- ERROR during PASS: the two-cycle response is passed unchanged. If the master then issues a transfer in the second cycle while blocked, it is held normally.
- Simultaneous set/clear conditions cannot occur: the set condition requires pend=0.
- Reset asserted mid-PEND: the held transfer is discarded and the block returns to PASS asynchronously.
- Width rules: controls pass through at full width; no arithmetic.

Decomposition:
- Shared package ahbmtx_l1_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP encodings: OKAY=2'b00, ERROR=2'b01.
  - Widths: ADDR_W, USER_W.
- One natural sub-module: ahbmtx_l1_hold_reg, the enable-loaded address-phase register bank with async reset. The pend FSM and muxes stay in the top.

Test Plan:
1. Reset, then NONSEQ 0x60090000 write with active_dec=1:
   - Same cycle: sel_in=1, addr_in=0x60090000, trans_in=2'b10.
   - Data phase: HREADYOUTS follows readyout_dec; pend never rises.
2. NONSEQ 0x40030004 with active_dec=0 for 3 cycles, then 1:
   - pend=1 for 4 cycles; HREADYOUTS=0 and HRESPS=OKAY throughout.
   - addr_in stays 0x40030004 while HADDRS changes to 0xDEAD0000.
   - ready_in=1 only in the grant cycle; return to PASS after it.
3. IDLE with HSELS=1 and active_dec=0: pend stays 0; HREADYOUTS equals readyout_dec (default slave: 1).
4. Decoder resp_dec=ERROR, readyout_dec 0 then 1:
   - HRESPS=ERROR for both cycles; HREADYOUTS=0 then 1.
   - A following NONSEQ with active_dec=0 enters PEND.
5. Assert HRESETn low during PEND:
   - pend=0, trans_in=IDLE, and HREADYOUTS=readyout_dec immediately (asynchronously).
   - The held address is not replayed after release.
6. Back-to-back SEQ burst with active_dec toggling 1,0,1:
   - Each beat is presented to the decoder exactly once, in order.
   - Beat 2 incurs 2 wait states.
